// File: rtl/demod_pkg.sv
// Shared constants for the lock-in demodulator: waveform bus field offsets,
// FSM/MAC encodings and default widths.
package demod_pkg;

    localparam int DAC_MSB  = 79;
    localparam int FREQ_MSB = 63;
    localparam int SIN_MSB  = 31;
    localparam int COS_MSB  = 15;

    localparam int ACC_W_DEF = 48;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } demod_state_t;

    typedef enum logic [1:0] {
        MAC_HOLD = 2'd0,
        MAC_LOAD = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_ZERO = 2'd3
    } mac_op_t;

endpackage

// File: rtl/demod_mac.sv
// One demodulation channel: registered signed 16x16 product feeding a
// wrapping accumulator with load/add/zero/hold control.
module demod_mac
    import demod_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      i_adc,
    input  logic [15:0]      i_ref,
    input  logic [1:0]       i_op,
    output logic [ACC_W-1:0] o_acc
);

    logic signed [31:0] r_prod;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_prod_ext;

    assign w_prod_ext = {{(ACC_W-32){r_prod[31]}}, r_prod};
    assign o_acc      = r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            r_prod <= $signed(i_adc) * $signed(i_ref);
            case (mac_op_t'(i_op))
                MAC_LOAD: r_acc <= w_prod_ext;
                MAC_ADD:  r_acc <= r_acc + w_prod_ext;
                MAC_ZERO: r_acc <= '0;
                default:  r_acc <= r_acc;
            endcase
        end
    end

endmodule

// File: rtl/lockin_demodulator.sv
// Lock-in I/Q demodulator: integrates adc*sin / adc*cos per constant-frequency
// segment and hands one result per segment to the readout. Optional DEMOD_SETTLE_EN.
//
// state    | meaning
// ST_IDLE  | no segment open, waiting for the first valid sample
// ST_ACCUM | segment open, accumulating samples of the latched frequency
module lockin_demodulator
    import demod_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             ADC_acquire,
    input  logic [15:0]      adc_data,
    input  logic [79:0]      output_freq_wfm,
    input  logic [15:0]      settle_samples,
    input  logic             result_ack,
    input  logic             clear_overrun,
    output logic             result_valid,
    output logic [ACC_W-1:0] result_i,
    output logic [ACC_W-1:0] result_q,
    output logic [31:0]      result_freq,
    output logic [CNT_W-1:0] result_count,
    output logic             busy,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic         r_valid_s1;
    logic [31:0]  r_freq_s1;

    demod_state_t r_state;
    demod_state_t w_next_state;
    logic         w_start;
    logic         w_cont;
    logic         w_close;
    logic         w_discard;
    mac_op_t      w_mac_op;

    logic [31:0]      r_seg_freq;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] w_acc_i;
    logic [ACC_W-1:0] w_acc_q;

    logic             r_res_valid;
    logic [ACC_W-1:0] r_res_i;
    logic [ACC_W-1:0] r_res_q;
    logic [31:0]      r_res_freq;
    logic [CNT_W-1:0] r_res_count;
    logic             r_overrun;
    logic             w_unused_dac;

    assign w_unused_dac = ^output_freq_wfm[DAC_MSB -: 16];

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_valid_s1 <= 1'b0;
            r_freq_s1  <= '0;
        end else begin
            r_valid_s1 <= ADC_acquire;
            r_freq_s1  <= output_freq_wfm[FREQ_MSB -: 32];
        end
    end

    demod_mac #(.ACC_W(ACC_W)) u_mac_i (
        .clk   (clk_50),
        .reset (reset),
        .i_adc (adc_data),
        .i_ref (output_freq_wfm[SIN_MSB -: 16]),
        .i_op  (w_mac_op),
        .o_acc (w_acc_i)
    );

    demod_mac #(.ACC_W(ACC_W)) u_mac_q (
        .clk   (clk_50),
        .reset (reset),
        .i_adc (adc_data),
        .i_ref (output_freq_wfm[COS_MSB -: 16]),
        .i_op  (w_mac_op),
        .o_acc (w_acc_q)
    );

    always_ff @(posedge clk_50) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // In ACCUM every cycle carries a valid sample, so a low valid is the falling edge.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_cont       = 1'b0;
        w_close      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_valid_s1) begin
                    w_start      = 1'b1;
                    w_next_state = ST_ACCUM;
                end
            end
            default: begin
                if (!r_valid_s1) begin
                    w_close      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if ((r_freq_s1 != r_seg_freq) || (r_count == CNT_MAX)) begin
                    w_close = 1'b1;
                    w_start = 1'b1;
                end else begin
                    w_cont = 1'b1;
                end
            end
        endcase
    end

`ifdef DEMOD_SETTLE_EN
    logic [15:0] r_settle_cnt;

    always_comb begin
        w_discard = 1'b0;
        if (w_start)     w_discard = (settle_samples != 16'd0);
        else if (w_cont) w_discard = (r_settle_cnt < settle_samples);
    end

    always_ff @(posedge clk_50) begin
        if (reset)                      r_settle_cnt <= '0;
        else if (w_start)               r_settle_cnt <= w_discard ? 16'd1 : 16'd0;
        else if (w_cont && w_discard)   r_settle_cnt <= r_settle_cnt + 16'd1;
    end
`else
    logic w_unused_settle;

    assign w_unused_settle = ^settle_samples;
    assign w_discard       = 1'b0;
`endif

    always_comb begin
        w_mac_op = MAC_HOLD;
        if (w_start)     w_mac_op = w_discard ? MAC_ZERO : MAC_LOAD;
        else if (w_cont) w_mac_op = w_discard ? MAC_HOLD : MAC_ADD;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_count    <= '0;
            r_seg_freq <= '0;
        end else if (w_start) begin
            r_count    <= w_discard ? '0 : CNT_W'(1);
            r_seg_freq <= r_freq_s1;
        end else if (w_cont && !w_discard) begin
            r_count    <= r_count + CNT_W'(1);
        end
    end

    // Hold registers capture the pre-update accumulators, so a closing sample
    // can start the next segment in the same cycle.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_i     <= '0;
            r_res_q     <= '0;
            r_res_freq  <= '0;
            r_res_count <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_close) begin
                r_res_valid <= 1'b1;
                r_res_i     <= w_acc_i;
                r_res_q     <= w_acc_q;
                r_res_freq  <= r_seg_freq;
                r_res_count <= r_count;
            end else if (result_ack) begin
                r_res_valid <= 1'b0;
            end
            if (w_close && r_res_valid && !result_ack) r_overrun <= 1'b1;
            else if (clear_overrun)                    r_overrun <= 1'b0;
        end
    end

    assign result_valid = r_res_valid;
    assign result_i     = r_res_i;
    assign result_q     = r_res_q;
    assign result_freq  = r_res_freq;
    assign result_count = r_res_count;
    assign busy         = (r_state == ST_ACCUM);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_lockin_demodulator.sv
// Bench for lockin_demodulator: segment-level reference model checked every cycle
// against two instances (default CNT_W and CNT_W=4), plus literal spot checks.
module tb_lockin_demodulator;

`ifdef DEMOD_SETTLE_EN
    localparam bit SETTLE_ON = 1'b1;
`else
    localparam bit SETTLE_ON = 1'b0;
`endif
    localparam logic [63:0] MASK48 = (64'd1 << 48) - 64'd1;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        ADC_acquire;
    logic [15:0] adc_data;
    logic [79:0] output_freq_wfm;
    logic [15:0] settle_samples;
    logic        result_ack;
    logic        clear_overrun;

    logic        v0, b0, o0, v4, b4, o4;
    logic [47:0] i0, q0, i4, q4;
    logic [31:0] f0, f4;
    logic [15:0] c0;
    logic [3:0]  c4;

    int tests_run = 0;
    int fails     = 0;
    bit chk_en    = 1'b0;

    always #10 clk_50 = ~clk_50;

    lockin_demodulator u_dut (
        .clk_50(clk_50), .reset(reset), .ADC_acquire(ADC_acquire), .adc_data(adc_data),
        .output_freq_wfm(output_freq_wfm), .settle_samples(settle_samples),
        .result_ack(result_ack), .clear_overrun(clear_overrun),
        .result_valid(v0), .result_i(i0), .result_q(q0), .result_freq(f0),
        .result_count(c0), .busy(b0), .overrun(o0)
    );

    lockin_demodulator #(.ACC_W(48), .CNT_W(4)) u_dut4 (
        .clk_50(clk_50), .reset(reset), .ADC_acquire(ADC_acquire), .adc_data(adc_data),
        .output_freq_wfm(output_freq_wfm), .settle_samples(settle_samples),
        .result_ack(result_ack), .clear_overrun(clear_overrun),
        .result_valid(v4), .result_i(i4), .result_q(q4), .result_freq(f4),
        .result_count(c4), .busy(b4), .overrun(o4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: segments, results and handshake in plain integer arithmetic.
    // p_* is the sample seen one edge earlier; results appear one edge after that.
    bit     p_valid;
    longint p_pi, p_pq, p_f;
    bit     m_open[2];
    longint m_seg_f[2], m_ai[2], m_aq[2];
    int     m_cnt[2], m_set[2];
    bit     e_valid[2], e_ovr[2];
    longint e_i[2], e_q[2], e_f[2];
    int     e_cnt[2];
    int     cmax[2] = '{65535, 15};
    bit     ld, st, ct, disc;
    longint li, lq, lf;
    int     lc;

    always @(posedge clk_50) begin
        if (reset) begin
            p_valid = 0; p_pi = 0; p_pq = 0; p_f = 0;
            for (int k = 0; k < 2; k++) begin
                m_open[k] = 0; m_seg_f[k] = 0; m_ai[k] = 0; m_aq[k] = 0; m_cnt[k] = 0; m_set[k] = 0;
                e_valid[k] = 0; e_ovr[k] = 0; e_i[k] = 0; e_q[k] = 0; e_f[k] = 0; e_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                ld = 0; st = 0; ct = 0;
                li = m_ai[k]; lq = m_aq[k]; lf = m_seg_f[k]; lc = m_cnt[k];
                if (m_open[k]) begin
                    if (!p_valid) begin
                        ld = 1; m_open[k] = 0;
                    end else if (p_f != m_seg_f[k] || m_cnt[k] == cmax[k]) begin
                        ld = 1; st = 1;
                    end else begin
                        ct = 1;
                    end
                end else if (p_valid) begin
                    st = 1;
                end
                if (st) begin
                    disc = SETTLE_ON && (settle_samples != 0);
                    m_open[k] = 1; m_seg_f[k] = p_f;
                    m_set[k] = disc ? 1 : 0;
                    m_cnt[k] = disc ? 0 : 1;
                    m_ai[k]  = disc ? 0 : p_pi;
                    m_aq[k]  = disc ? 0 : p_pq;
                end
                if (ct) begin
                    disc = SETTLE_ON && (m_set[k] < int'(settle_samples));
                    if (disc) m_set[k]++;
                    else begin
                        m_cnt[k]++; m_ai[k] += p_pi; m_aq[k] += p_pq;
                    end
                end
                if (ld && e_valid[k] && !result_ack) e_ovr[k] = 1;
                else if (clear_overrun)              e_ovr[k] = 0;
                if (ld) begin
                    e_valid[k] = 1; e_i[k] = li; e_q[k] = lq; e_f[k] = lf; e_cnt[k] = lc;
                end else if (result_ack) begin
                    e_valid[k] = 0;
                end
            end
            p_valid = ADC_acquire;
            p_pi    = longint'($signed(adc_data)) * longint'($signed(output_freq_wfm[31:16]));
            p_pq    = longint'($signed(adc_data)) * longint'($signed(output_freq_wfm[15:0]));
            p_f     = longint'(output_freq_wfm[63:32]);
        end
    end

    always @(negedge clk_50) begin
        if (chk_en) begin
            chk("valid",  64'(v0), 64'(e_valid[0]));
            chk("busy",   64'(b0), 64'(m_open[0]));
            chk("ovr",    64'(o0), 64'(e_ovr[0]));
            chk("res_i",  64'(i0), 64'(e_i[0]) & MASK48);
            chk("res_q",  64'(q0), 64'(e_q[0]) & MASK48);
            chk("freq",   64'(f0), 64'(e_f[0]));
            chk("count",  64'(c0), 64'(e_cnt[0]));
            chk("valid4", 64'(v4), 64'(e_valid[1]));
            chk("busy4",  64'(b4), 64'(m_open[1]));
            chk("ovr4",   64'(o4), 64'(e_ovr[1]));
            chk("res_i4", 64'(i4), 64'(e_i[1]) & MASK48);
            chk("res_q4", 64'(q4), 64'(e_q[1]) & MASK48);
            chk("freq4",  64'(f4), 64'(e_f[1]));
            chk("count4", 64'(c4), 64'(e_cnt[1]));
        end
    end

    task automatic cyc(input bit v, input logic [15:0] a, input logic [15:0] s,
                       input logic [15:0] c, input logic [31:0] f);
        ADC_acquire     = v;
        adc_data        = a;
        output_freq_wfm = {16'hABCD, f, s, c};
        @(posedge clk_50);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 16'h0, 16'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; ADC_acquire = 1'b0; adc_data = '0; output_freq_wfm = '0;
        settle_samples = '0; result_ack = 1'b0; clear_overrun = 1'b0;
        repeat (3) @(posedge clk_50);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_busy",  64'(b0), 64'd0);

        // 1: single segment, closed by valid falling
        for (int n = 0; n < 8; n++) cyc(1'b1, 16'h4000, 16'h4000, 16'h0, 32'd100);
        idle();
        chk("t1_not_yet", 64'(v0), 64'd0);
        idle();
        chk("t1_valid", 64'(v0), 64'd1);
        chk("t1_i",     64'(i0), 64'h8000_0000);
        chk("t1_q",     64'(q0), 64'd0);
        chk("t1_freq",  64'(f0), 64'd100);
        chk("t1_count", 64'(c0), 64'd8);
        chk("t1_busy",  64'(b0), 64'd0);
        result_ack = 1'b1;
        idle();
        chk("t1_acked", 64'(v0), 64'd0);

        // 2: frequency step closes and reopens without a gap
        for (int n = 0; n < 5; n++) cyc(1'b1, 16'h2000, 16'h1000, 16'h0800, 32'd100);
        cyc(1'b1, 16'h2000, 16'h1000, 16'h0800, 32'd200);
        cyc(1'b1, 16'h2000, 16'h1000, 16'h0800, 32'd200);
        chk("t2_freq_a",  64'(f0), 64'd100);
        chk("t2_count_a", 64'(c0), 64'd5);
        chk("t2_busy",    64'(b0), 64'd1);
        cyc(1'b1, 16'h2000, 16'h1000, 16'h0800, 32'd200);
        idle();
        idle();
        chk("t2_valid_b", 64'(v0), 64'd1);
        chk("t2_freq_b",  64'(f0), 64'd200);
        chk("t2_count_b", 64'(c0), 64'd3);
        chk("t2_idle",    64'(b0), 64'd0);
        idle();
        result_ack = 1'b0;

        // 3: unacknowledged results overrun
        cyc(1'b1, 16'h1000, 16'h2000, 16'h7FFF, 32'd300);
        cyc(1'b1, 16'h1000, 16'h2000, 16'h7FFF, 32'd300);
        cyc(1'b1, 16'h0100, 16'h0100, 16'h0100, 32'd400);
        idle();
        idle();
        chk("t3_ovr",   64'(o0), 64'd1);
        chk("t3_freq",  64'(f0), 64'd400);
        chk("t3_count", 64'(c0), 64'd1);
        chk("t3_q",     64'(q0), 64'h1_0000);
        clear_overrun = 1'b1;
        idle();
        clear_overrun = 1'b0;
        chk("t3_ovr_clr", 64'(o0), 64'd0);
        chk("t3_still",   64'(v0), 64'd1);
        result_ack = 1'b1;
        idle();
        chk("t3_acked", 64'(v0), 64'd0);

        // 4a: most-negative times most-negative is positive
        for (int n = 0; n < 3; n++) cyc(1'b1, 16'h8000, 16'h8000, 16'h8000, 32'd600);
        idle();
        idle();
        chk("t4_i", 64'(i0), 64'hC000_0000);
        chk("t4_q", 64'(q0), 64'hC000_0000);

        // 4b: forced close at full count on the CNT_W=4 instance
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b1, 16'h0001, 16'h0001, 16'hFFFF, 32'd700);
            if (n == 17) begin
                chk("t4_force_valid", 64'(v4), 64'd1);
                chk("t4_force_count", 64'(c4), 64'd15);
                chk("t4_force_q",     64'(q4), (-64'd15) & MASK48);
            end
        end
        idle();
        idle();
        chk("t4_tail_count4", 64'(c4), 64'd5);
        chk("t4_tail_i4",     64'(i4), 64'd5);
        chk("t4_full_count",  64'(c0), 64'd20);

        // 5: settling (ignored in the default build)
        settle_samples = 16'd3;
        for (int n = 0; n < 10; n++) cyc(1'b1, 16'h0100, 16'h0100, 16'h0, 32'd800);
        idle();
        idle();
        chk("t5_count", 64'(c0), SETTLE_ON ? 64'd7 : 64'd10);
        chk("t5_i",     64'(i0), SETTLE_ON ? 64'h7_0000 : 64'hA_0000);
        for (int n = 0; n < 2; n++) cyc(1'b1, 16'h0100, 16'h0100, 16'h0100, 32'd900);
        idle();
        idle();
        chk("t5_short_count", 64'(c0), SETTLE_ON ? 64'd0 : 64'd2);
        chk("t5_short_i",     64'(i0), SETTLE_ON ? 64'd0 : 64'h2_0000);
        chk("t5_short_q",     64'(q0), SETTLE_ON ? 64'd0 : 64'h2_0000);
        settle_samples = 16'd0;

        // 6: reset mid-segment
        for (int n = 0; n < 4; n++) cyc(1'b1, 16'h0100, 16'h0100, 16'h0, 32'd1000);
        reset = 1'b1;
        cyc(1'b1, 16'h0100, 16'h0100, 16'h0, 32'd1000);
        reset = 1'b0;
        chk("t6_valid", 64'(v0), 64'd0);
        chk("t6_busy",  64'(b0), 64'd0);
        chk("t6_i",     64'(i0), 64'd0);
        chk("t6_freq",  64'(f0), 64'd0);
        chk("t6_count", 64'(c0), 64'd0);
        chk("t6_ovr",   64'(o0), 64'd0);
        for (int n = 0; n < 3; n++) cyc(1'b1, 16'h0100, 16'h0100, 16'h0, 32'd1100);
        idle();
        idle();
        chk("t6_new_valid", 64'(v0), 64'd1);
        chk("t6_new_count", 64'(c0), 64'd3);
        chk("t6_new_freq",  64'(f0), 64'd1100);

        repeat (3) idle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
